// File: rtl/mul_repeated_add_if.sv
// Operand/result bus of the repeated-addition multiplier.
interface mul_repeated_add_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             eqz;

  // Requester side: issues start and operands, observes the result.
  modport master (
    output start,
    output data_in,
    input  done,
    input  product,
    input  eqz
  );

  // Multiplier side.
  modport slave (
    input  start,
    input  data_in,
    output done,
    output product,
    output eqz
  );
endinterface

// File: rtl/mul_repeated_add.sv
// Unsigned sequential multiplier: product = A * B by adding A to P B times.
// Operands arrive serially on data_in (A, then B) after start is seen in IDLE.
module mul_repeated_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mul_repeated_add_if.slave  bus
);

  localparam int unsigned W = WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ACC,
    S_DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   p_q;
  logic           done_q;

  logic           ld_a;
  logic           ld_b;
  logic           clr_p;
  logic           ld_p;
  logic           dec_b;
  logic           eqz_c;

  // Zero-detect on the down-counter; only depends on B.
  assign eqz_c = (b_q == W'(0));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore control decode.
  always_comb begin
    state_d = state_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    clr_p   = 1'b0;
    ld_p    = 1'b0;
    dec_b   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        ld_a    = 1'b1;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        ld_b    = 1'b1;
        clr_p   = 1'b1;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (eqz_c) begin
          state_d = S_DONE;
        end else begin
          ld_p  = 1'b1;
          dec_b = 1'b1;
        end
      end
      S_DONE: begin
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: A operand, B down-counter, P accumulator (wraps).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      if (ld_a) a_q <= bus.data_in;
      if (ld_b) begin
        b_q <= bus.data_in;
      end else if (dec_b) begin
        b_q <= b_q - W'(1);
      end
      if (clr_p) begin
        p_q <= '0;
      end else if (ld_p) begin
        p_q <= p_q + a_q;
      end
    end
  end

  // done is registered from the next state so it is high exactly while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_d == S_DONE);
    end
  end

  assign bus.done    = done_q;
  assign bus.product = p_q;
  assign bus.eqz     = eqz_c;

endmodule

// File: tb/tb_mul_repeated_add.sv
// Self-checking bench for mul_repeated_add against an arithmetic reference.
module tb_mul_repeated_add;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned BOUND = 64;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mul_repeated_add_if #(.WIDTH(WIDTH)) bus ();

  mul_repeated_add #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // Issue one multiply and follow it to DONE. Every ACC cycle is checked
  // against the arithmetic expectation P = a*n after n adds, B = b-n.
  // lat counts edges from the one that samples start to the one raising done.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit hold,
                         output logic [31:0] p, output int lat);
    logic [31:0] exp_p;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = $urandom;
    @(posedge clk);
    @(negedge clk);
    bus.start   = hold ? 1'b1 : 1'($urandom_range(0, 1));
    bus.data_in = a;
    @(posedge clk);
    @(negedge clk);
    bus.start   = hold ? 1'b1 : 1'($urandom_range(0, 1));
    bus.data_in = b;
    @(posedge clk);
    #1;
    lat = -1;
    for (int n = 0; n < int'(BOUND); n++) begin
      if (bus.done === 1'b1) begin
        lat = n + 2;
        break;
      end
      exp_p = a * 32'(n);
      checks++;
      if (bus.product !== exp_p || bus.eqz !== 1'(b == 32'(n))) begin
        errors++;
        $display("FAIL acc_step a=%0d b=%0d n=%0d: product=%0d eqz=%0b, required product=%0d eqz=%0b",
                 a, b, n, bus.product, bus.eqz, exp_p, (b == 32'(n)));
      end
      @(negedge clk);
      bus.start   = hold ? 1'b1 : 1'($urandom_range(0, 1));
      bus.data_in = $urandom;
      @(posedge clk);
      #1;
    end
    if (lat < 0) begin
      errors++;
      $display("FAIL done_timeout a=%0d b=%0d: done never rose within %0d cycles", a, b, BOUND);
    end
    p = bus.product;
  endtask

  // Drop start in DONE and confirm return to IDLE on the next edge.
  task automatic release_done(input logic [31:0] exp_p);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.product !== exp_p) begin
      errors++;
      $display("FAIL to_idle: done=%0b product=%0d, required done=0 product=%0d",
               bus.done, bus.product, exp_p);
    end
  endtask

  // Full multiply with result and latency checks against the model.
  task automatic check_mul(input string name, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    logic [31:0] exp_p;
    int          lat;
    exp_p = a * b;
    run_mul(a, b, 1'b0, p, lat);
    checks++;
    if (p !== exp_p) begin
      errors++;
      $display("FAIL %s product a=%0h b=%0d: got %0h, required %0h", name, a, b, p, exp_p);
    end
    checks++;
    if (lat != int'(b) + 3) begin
      errors++;
      $display("FAIL %s latency b=%0d: got %0d edges, required %0d", name, b, lat, int'(b) + 3);
    end
    release_done(exp_p);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.product !== 32'd0 || bus.eqz !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: done=%0b product=%0d eqz=%0b, required 0/0/1",
               bus.done, bus.product, bus.eqz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: done=%0b, required 0", bus.done);
    end
  endtask

  task automatic test_basic();
    check_mul("basic_17x5", 32'd17, 32'd5);
  endtask

  task automatic test_b_zero();
    check_mul("b_zero", 32'd9, 32'd0);
  endtask

  task automatic test_a_zero();
    check_mul("a_zero", 32'd0, 32'd7);
  endtask

  task automatic test_wrap();
    check_mul("wrap", 32'hFFFF_FFFF, 32'd3);
  endtask

  // Async reset during ACC aborts immediately; a fresh multiply then works.
  task automatic test_reset_mid();
    @(negedge clk);
    bus.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = 32'd17;
    @(posedge clk);
    @(negedge clk);
    bus.data_in = 32'd5;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.product !== 32'd51) begin
      errors++;
      $display("FAIL pre_abort_p: product=%0d, required 51", bus.product);
    end
    rst_n = 1'b0;
    #0.5;
    checks++;
    if (bus.done !== 1'b0 || bus.product !== 32'd0 || bus.eqz !== 1'b1) begin
      errors++;
      $display("FAIL abort_now: done=%0b product=%0d eqz=%0b, required 0/0/1",
               bus.done, bus.product, bus.eqz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.product !== 32'd0) begin
      errors++;
      $display("FAIL abort_idle: done=%0b product=%0d, required 0/0", bus.done, bus.product);
    end
    check_mul("after_abort", 32'd17, 32'd5);
  endtask

  // start held through DONE: no retrigger, result stable, data_in ignored.
  task automatic test_hold_start();
    logic [31:0] p;
    int          lat;
    run_mul(32'd6, 32'd4, 1'b1, p, lat);
    checks++;
    if (p !== 32'd24 || lat != 7) begin
      errors++;
      $display("FAIL hold_result: product=%0d lat=%0d, required 24 and 7", p, lat);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.data_in = $urandom;
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b1 || bus.product !== 32'd24) begin
        errors++;
        $display("FAIL hold_stable i=%0d: done=%0b product=%0d, required 1/24",
                 i, bus.done, bus.product);
      end
    end
    release_done(32'd24);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      check_mul("random", $urandom, 32'($urandom_range(0, 20)));
    end
  endtask

  task automatic test_back_to_back();
    check_mul("b2b_0", 32'd1, 32'd1);
    check_mul("b2b_1", 32'h8000_0000, 32'd2);
    check_mul("b2b_2", 32'd12345, 32'd19);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_b_zero();
    test_a_zero();
    test_wrap();
    test_reset_mid();
    test_hold_start();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
